mode_controller: RTL and testbench

// - Central UI state machine of the multimode clock. It consumes the one-cycle

---
 rtl/mode_controller.sv | 133 +++++++++++++
 tb/tb_mode_controller.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_controller.sv
// mode_controller: UI state machine of the multimode clock; all outputs registered.
// Optional edit auto-exit on idle timeout when MODE_CTRL_AUTO_EXIT_EN is defined.
module mode_controller #(
    parameter int unsigned TIMEOUT = 1_000_000_000,
    parameter int unsigned CNT_W   = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       set_btn,
    input  logic       inc_btn,
    output logic [1:0] mode,
    output logic [1:0] edit_field,
    output logic       edit_active,
    output logic       inc_hours,
    output logic       inc_minutes,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       alarm_en
);

    localparam logic [1:0] ModeAlarm = 2'd1;
    localparam logic [1:0] ModeSw    = 2'd2;

    typedef enum logic [1:0] {StNone = 2'd0, StHours = 2'd1, StMinutes = 2'd2} field_e;

    field_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       sw_run_q, sw_run_d;
    logic       alarm_en_q, alarm_en_d;
    logic       edit_active_q;
    logic       inc_hours_q, inc_hours_d;
    logic       inc_minutes_q, inc_minutes_d;
    logic       sw_clear_q, sw_clear_d;
    logic       inc_only;
    logic       expire;

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_cnt_w_check
        $error("CNT_W too narrow to hold TIMEOUT");
    end

    // inc_btn only acts when it wins priority
    assign inc_only = inc_btn && !set_btn && !mode_btn;

`ifdef MODE_CTRL_AUTO_EXIT_EN
    logic [CNT_W-1:0] idle_q, idle_d;

    assign expire = (idle_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        idle_d = idle_q + CNT_W'(1);
        if (set_btn || mode_btn || inc_btn || state_q == StNone || expire) begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StNone;
            mode_q        <= 2'd0;
            sw_run_q      <= 1'b0;
            alarm_en_q    <= 1'b0;
            edit_active_q <= 1'b0;
            inc_hours_q   <= 1'b0;
            inc_minutes_q <= 1'b0;
            sw_clear_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            sw_run_q      <= sw_run_d;
            alarm_en_q    <= alarm_en_d;
            edit_active_q <= (state_d != StNone);
            inc_hours_q   <= inc_hours_d;
            inc_minutes_q <= inc_minutes_d;
            sw_clear_q    <= sw_clear_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sw_run_d   = sw_run_q;
        alarm_en_d = alarm_en_q;
        if (set_btn) begin
            if (mode_q == ModeSw) begin
                sw_run_d = ~sw_run_q;
            end else begin
                unique case (state_q)
                    StNone:  state_d = StHours;
                    StHours: state_d = StMinutes;
                    default: state_d = StNone;
                endcase
            end
        end else if (mode_btn) begin
            if (state_q == StNone) begin
                mode_d = mode_q + 2'd1;
            end
        end else if (inc_btn) begin
            if (state_q == StNone && mode_q == ModeAlarm) begin
                alarm_en_d = ~alarm_en_q;
            end
        end else if (expire) begin
            state_d = StNone;
        end
    end

    always_comb begin
        inc_hours_d   = inc_only && (state_q == StHours);
        inc_minutes_d = inc_only && (state_q == StMinutes);
        sw_clear_d    = inc_only && (state_q == StNone) && (mode_q == ModeSw) && !sw_run_q;
    end

    assign mode        = mode_q;
    assign edit_field  = state_q;
    assign edit_active = edit_active_q;
    assign inc_hours   = inc_hours_q;
    assign inc_minutes = inc_minutes_q;
    assign sw_run      = sw_run_q;
    assign sw_clear    = sw_clear_q;
    assign alarm_en    = alarm_en_q;

endmodule

// File: tb/tb_mode_controller.sv
// Self-checking bench for mode_controller: a reference model pushes expected outputs per
// driven cycle onto a scoreboard queue; each test pops and compares after the edge.
module tb_mode_controller;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 5;

    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] field;
        logic       act;
        logic       ih;
        logic       im;
        logic       run;
        logic       clr;
        logic       al;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       mode_btn;
    logic       set_btn;
    logic       inc_btn;
    logic [1:0] mode;
    logic [1:0] edit_field;
    logic       edit_active;
    logic       inc_hours;
    logic       inc_minutes;
    logic       sw_run;
    logic       sw_clear;
    logic       alarm_en;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    logic [1:0] m_mode;
    logic [1:0] m_field;
    logic       m_run;
    logic       m_al;
    int         m_cnt;

    mode_controller #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_btn    (mode_btn),
        .set_btn     (set_btn),
        .inc_btn     (inc_btn),
        .mode        (mode),
        .edit_field  (edit_field),
        .edit_active (edit_active),
        .inc_hours   (inc_hours),
        .inc_minutes (inc_minutes),
        .sw_run      (sw_run),
        .sw_clear    (sw_clear),
        .alarm_en    (alarm_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t obs();
        return {mode, edit_field, edit_active, inc_hours, inc_minutes, sw_run, sw_clear,
                alarm_en};
    endfunction

    task automatic model_reset();
        m_mode  = 2'd0;
        m_field = 2'd0;
        m_run   = 1'b0;
        m_al    = 1'b0;
        m_cnt   = 0;
        sb.delete();
    endtask

    // One cycle of pulses {s,m,i}: model predicts the post-edge outputs and queues them.
    task automatic drive(input logic s, input logic m, input logic i);
        exp_t       e;
        logic [1:0] f0;
        @(negedge clk);
        set_btn  = s;
        mode_btn = m;
        inc_btn  = i;
        e  = '0;
        f0 = m_field;
        if (s) begin
            if (m_mode == 2'd2) m_run = ~m_run;
            else m_field = (m_field == 2'd2) ? 2'd0 : m_field + 2'd1;
        end else if (m) begin
            if (m_field == 2'd0) m_mode = m_mode + 2'd1;
        end else if (i) begin
            if (m_field == 2'd1) e.ih = 1'b1;
            else if (m_field == 2'd2) e.im = 1'b1;
            else if (m_mode == 2'd1) m_al = ~m_al;
            else if (m_mode == 2'd2 && !m_run) e.clr = 1'b1;
        end
`ifdef MODE_CTRL_AUTO_EXIT_EN
        if (s || m || i || f0 == 2'd0) begin
            m_cnt = 0;
        end else if (m_cnt == int'(TIMEOUT) - 1) begin
            m_field = 2'd0;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
`else
        m_cnt = int'(f0);
`endif
        e.mode  = m_mode;
        e.field = m_field;
        e.act   = (m_field != 2'd0);
        e.run   = m_run;
        e.al    = m_al;
        sb.push_back(e);
        @(posedge clk);
        #1;
        set_btn  = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== exp_t'(0)) begin
            $display("FAIL reset_state: got %b want %b", obs(), exp_t'(0));
            errors++;
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_mode_cycle();
        logic [1:0] want [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                $display("FAIL mode_cycle[%0d]: got %b want %b", k, obs(), e);
                errors++;
            end
            checks++;
            if (mode !== want[k]) begin
                $display("FAIL mode_value[%0d]: got %0d want %0d", k, mode, want[k]);
                errors++;
            end
        end
    endtask

    task automatic test_clock_edit();
        logic [2:0] seq [6] = '{3'b100, 3'b001, 3'b001, 3'b100, 3'b001, 3'b100};
        exp_t e;
        int   nh = 0;
        int   nm = 0;
        for (int k = 0; k < 6; k++) begin
            drive(seq[k][2], seq[k][1], seq[k][0]);
            e = sb.pop_front();
            nh += int'(inc_hours);
            nm += int'(inc_minutes);
            checks++;
            if (obs() !== e) begin
                $display("FAIL clock_edit[%0d]: got %b want %b", k, obs(), e);
                errors++;
            end
        end
        checks++;
        if (nh != 2 || nm != 1 || edit_field !== 2'd0) begin
            $display("FAIL clock_edit_counts: got h=%0d m=%0d field=%0d want h=2 m=1 field=0",
                     nh, nm, edit_field);
            errors++;
        end
    endtask

    task automatic test_stopwatch();
        logic [2:0] seq [10] = '{3'b010, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b000,
                                 3'b100, 3'b010, 3'b010};
        exp_t e;
        int   nclr = 0;
        for (int k = 0; k < 10; k++) begin
            drive(seq[k][2], seq[k][1], seq[k][0]);
            e = sb.pop_front();
            nclr += int'(sw_clear);
            checks++;
            if (obs() !== e) begin
                $display("FAIL stopwatch[%0d]: got %b want %b", k, obs(), e);
                errors++;
            end
            if (k == 8) begin
                checks++;
                if (mode !== 2'd3 || sw_run !== 1'b1) begin
                    $display("FAIL sw_background: got mode=%0d run=%b want mode=3 run=1",
                             mode, sw_run);
                    errors++;
                end
            end
        end
        checks++;
        if (nclr != 1) begin
            $display("FAIL sw_clear_count: got %0d want 1", nclr);
            errors++;
        end
    endtask

    task automatic test_priority();
        logic [2:0] seq [5] = '{3'b111, 3'b010, 3'b011, 3'b100, 3'b100};
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            drive(seq[k][2], seq[k][1], seq[k][0]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                $display("FAIL priority[%0d]: got %b want %b", k, obs(), e);
                errors++;
            end
            if (k <= 2) begin
                checks++;
                if (mode !== 2'd0 || edit_field !== 2'd1 || inc_hours !== 1'b0) begin
                    $display("FAIL priority_win[%0d]: got mode=%0d field=%0d ih=%b want 0 1 0",
                             k, mode, edit_field, inc_hours);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_alarm();
        logic [2:0] seq [7] = '{3'b010, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010};
        exp_t e;
        for (int k = 0; k < 7; k++) begin
            drive(seq[k][2], seq[k][1], seq[k][0]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                $display("FAIL alarm[%0d]: got %b want %b", k, obs(), e);
                errors++;
            end
        end
        checks++;
        if (alarm_en !== 1'b1 || mode !== 2'd0) begin
            $display("FAIL alarm_persist: got al=%b mode=%0d want al=1 mode=0", alarm_en, mode);
            errors++;
        end
    endtask

    task automatic test_auto_exit();
        exp_t e;
        int   exit_at = 0;
        drive(1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            $display("FAIL auto_enter: got %b want %b", obs(), e);
            errors++;
        end
`ifdef MODE_CTRL_AUTO_EXIT_EN
        for (int n = 1; n <= 40 && exit_at == 0; n++) begin
            drive(1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                $display("FAIL auto_idle[%0d]: got %b want %b", n, obs(), e);
                errors++;
            end
            if (edit_field === 2'd0) exit_at = n;
        end
        checks++;
        if (exit_at != int'(TIMEOUT)) begin
            $display("FAIL auto_exit_time: got %0d want %0d", exit_at, TIMEOUT);
            errors++;
        end
        drive(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        for (int n = 1; n < int'(TIMEOUT); n++) begin
            drive(1'b0, 1'b0, 1'b0);
            void'(sb.pop_front());
        end
        drive(1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        checks++;
        if (obs() !== e || inc_hours !== 1'b1 || edit_field !== 2'd1) begin
            $display("FAIL auto_collision: got %b want %b", obs(), e);
            errors++;
        end
        exit_at = 0;
        for (int n = 1; n <= 40 && exit_at == 0; n++) begin
            drive(1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                $display("FAIL auto_idle2[%0d]: got %b want %b", n, obs(), e);
                errors++;
            end
            if (edit_field === 2'd0) exit_at = n;
        end
        checks++;
        if (exit_at != int'(TIMEOUT)) begin
            $display("FAIL auto_exit_after_pulse: got %0d want %0d", exit_at, TIMEOUT);
            errors++;
        end
`else
        for (int n = 1; n <= 40; n++) begin
            drive(1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            if (edit_field === 2'd0 && exit_at == 0) exit_at = n;
        end
        checks++;
        if (exit_at != 0 || obs() !== e) begin
            $display("FAIL edit_persists: got exit_at=%0d out=%b want 0 %b", exit_at, obs(), e);
            errors++;
        end
        drive(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs() !== e || edit_field !== 2'd0) begin
            $display("FAIL edit_exit_by_set: got %b want %b", obs(), e);
            errors++;
        end
`endif
    endtask

    task automatic test_reset_mid_edit();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs() !== e || edit_field !== 2'd1) begin
            $display("FAIL rst_edit_enter: got %b want %b", obs(), e);
            errors++;
        end
        @(negedge clk);
        inc_btn = 1'b1;
        reset   = 1'b1;
        #1;
        checks++;
        if (obs() !== exp_t'(0)) begin
            $display("FAIL rst_async: got %b want %b", obs(), exp_t'(0));
            errors++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== exp_t'(0) || inc_hours !== 1'b0) begin
            $display("FAIL rst_no_strobe: got %b want %b", obs(), exp_t'(0));
            errors++;
        end
        @(negedge clk);
        inc_btn = 1'b0;
        reset   = 1'b0;
        model_reset();
        drive(1'b0, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs() !== e || mode !== 2'd1) begin
            $display("FAIL rst_recover: got %b want %b", obs(), e);
            errors++;
        end
    endtask

    initial begin
        set_btn  = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        reset    = 1'b1;
        model_reset();
        test_reset();
        test_mode_cycle();
        test_clock_edit();
        test_stopwatch();
        test_priority();
        test_alarm();
        test_auto_exit();
        test_reset_mid_edit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
